// File: rtl/trace_pkg.sv
// Shared constants and types for the write-back trace transmitter.
package trace_pkg;

   localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
   localparam int unsigned BYTES_PER_REC = 8;
   localparam int unsigned PC_W_DFLT     = 12;
   localparam int unsigned REC_W         = PC_W_DFLT + 37;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_e;

   // Record = {pc, rd[4:0], data[31:0]}
   function automatic int unsigned rec_width(input int unsigned pc_w);
      return pc_w + 37;
   endfunction

endpackage

// File: rtl/wb_trace_tx_if.sv
// Regfile write snoop inputs plus the outgoing valid/ready byte stream.
interface wb_trace_tx_if #(
   parameter int unsigned PC_W = 12
);
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [31:0]     wb_data;
   logic [PC_W-1:0] wb_pc;
   logic            tx_valid;
   logic [7:0]      tx_data;
   logic            tx_ready;

   modport master (
      input  wb_we, wb_rd, wb_data, wb_pc, tx_ready,
      output tx_valid, tx_data
   );

   modport slave (
      output wb_we, wb_rd, wb_data, wb_pc, tx_ready,
      input  tx_valid, tx_data
   );
endinterface

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO; requests that would overflow or underflow are ignored.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WIDTH  = REC_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wptr_q, rptr_q;
   logic [ADDR_W:0]   level_q;
   logic              do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (ADDR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rptr_q];
   assign level   = level_q;

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wptr_q] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + ADDR_W'(1);
         if (do_pop)  rptr_q <= rptr_q + ADDR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_tx.sv
// Write-back trace transmitter: buffers regfile writes and emits 8-byte packets
// (A5, rd, pc16 hi/lo, data big-endian) on a valid/ready byte stream.
module wb_trace_tx
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned PC_W   = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             trace_en,
   input  logic             clr_stats,
   wb_trace_tx_if.master    bus,
   output logic [ADDR_W:0]  fifo_level,
   output logic [15:0]      drop_cnt,
   output logic             overflow
);

   localparam int unsigned RecW = rec_width(PC_W);

   logic            push_req, fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
   logic [RecW-1:0] rec_in, fifo_dout, hold_q, hold_d;
   tx_state_e       state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [15:0]     drop_q, pc16;
   logic            ovf_q;
   logic [7:0]      tx_byte;

   assign push_req  = trace_en && bus.wb_we && (bus.wb_rd != 5'd0);
   assign rec_in    = {bus.wb_pc, bus.wb_rd, bus.wb_data};
   assign drop      = push_req && fifo_full && !fifo_pop;
   assign fifo_push = push_req && !drop;

   trace_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (RecW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rec_in),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      hold_d   = hold_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               hold_d   = fifo_dout;
               idx_d    = 3'd0;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.tx_ready) begin
               if (idx_q != 3'(BYTES_PER_REC - 1)) begin
                  idx_d = idx_q + 3'd1;
               end else if (!fifo_empty) begin
                  // Chain straight into the next record: no idle bubble between packets.
                  fifo_pop = 1'b1;
                  hold_d   = fifo_dout;
                  idx_d    = 3'd0;
               end else begin
                  idx_d   = 3'd0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || clr_stats) begin
         drop_q <= 16'd0;
         ovf_q  <= 1'b0;
      end else if (drop) begin
         if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         ovf_q <= 1'b1;
      end
   end

   assign drop_cnt = drop_q;
   assign overflow = ovf_q;

   always_comb begin
      pc16 = 16'(hold_q[RecW-1:37]);
      case (idx_q)
         3'd0:    tx_byte = SYNC_BYTE;
         3'd1:    tx_byte = {3'b000, hold_q[36:32]};
         3'd2:    tx_byte = pc16[15:8];
         3'd3:    tx_byte = pc16[7:0];
         3'd4:    tx_byte = hold_q[31:24];
         3'd5:    tx_byte = hold_q[23:16];
         3'd6:    tx_byte = hold_q[15:8];
         default: tx_byte = hold_q[7:0];
      endcase
   end

   assign bus.tx_valid = (state_q == ST_SEND);
   assign bus.tx_data  = (state_q == ST_SEND) ? tx_byte : 8'h00;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Directed bench for wb_trace_tx: packet format, filtering, backpressure, overflow, reset.
module tb_wb_trace_tx;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned PC_W   = 12;

   logic             clock     = 1'b0;
   logic             reset     = 1'b0;
   logic             trace_en  = 1'b0;
   logic             clr_stats = 1'b0;
   logic [ADDR_W:0]  fifo_level;
   logic [15:0]      drop_cnt;
   logic             overflow;

   wb_trace_tx_if #(.PC_W(PC_W)) bus ();

   wb_trace_tx #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PC_W   (PC_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .trace_en   (trace_en),
      .clr_stats  (clr_stats),
      .bus        (bus),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]      rd;
      logic [31:0]     data;
      logic [PC_W-1:0] pc;
   } rec_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic rec_t mk(input int i);
      rec_t r;
      r.rd   = 5'((i % 31) + 1);
      r.data = 32'hC0DE0000 | 32'(i);
      r.pc   = PC_W'(12'h100 + i);
      return r;
   endfunction

   function automatic logic [7:0] pkt_byte(input rec_t r, input int i);
      logic [15:0] pc16;
      pc16 = 16'(r.pc);
      case (i)
         0:       return 8'hA5;
         1:       return {3'b000, r.rd};
         2:       return pc16[15:8];
         3:       return pc16[7:0];
         4:       return r.data[31:24];
         5:       return r.data[23:16];
         6:       return r.data[15:8];
         default: return r.data[7:0];
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_rec(input rec_t r);
      bus.wb_we   = 1'b1;
      bus.wb_rd   = r.rd;
      bus.wb_data = r.data;
      bus.wb_pc   = r.pc;
   endtask

   task automatic write(input rec_t r);
      drive_rec(r);
      step();
      bus.wb_we = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int c = 0; c < 40 && !bus.tx_valid; c++) step();
      check_eq(tag, 32'(bus.tx_valid), 32'd1);
   endtask

   // Consume bytes first..last of r with tx_ready high, optionally stalling at stall_idx.
   task automatic recv_bytes(input rec_t r, input int first, input int last,
                             input int stall_idx, input int stall_n);
      for (int i = first; i <= last; i++) begin
         if (i == stall_idx) begin
            bus.tx_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               step();
               check_eq("stall_valid", 32'(bus.tx_valid), 32'd1);
               check_eq("stall_data", 32'(bus.tx_data), 32'(pkt_byte(r, i)));
            end
            bus.tx_ready = 1'b1;
         end
         check_eq($sformatf("b%0d_valid", i), 32'(bus.tx_valid), 32'd1);
         check_eq($sformatf("b%0d_data", i), 32'(bus.tx_data), 32'(pkt_byte(r, i)));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      rec_t r;
      rec_t r_extra;
      bus.wb_we    = 1'b0;
      bus.wb_rd    = '0;
      bus.wb_data  = '0;
      bus.wb_pc    = '0;
      bus.tx_ready = 1'b1;
      trace_en     = 1'b1;
      reset        = 1'b0;
      step();
      step();
      check_eq("rst_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("rst_data", 32'(bus.tx_data), 32'd0);
      check_eq("rst_level", 32'(fifo_level), 32'd0);
      check_eq("rst_drop", 32'(drop_cnt), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b1;
      step();

      // Basic packet: A5 03 00 12 DE AD BE EF, valid two edges after capture.
      r = '{rd: 5'd3, data: 32'hDEADBEEF, pc: 12'h012};
      write(r);
      check_eq("t1_level", 32'(fifo_level), 32'd1);
      check_eq("t1_lat_valid", 32'(bus.tx_valid), 32'd0);
      step();
      check_eq("t1_b0", 32'(bus.tx_data), 32'hA5);
      recv_bytes(r, 0, 3, -1, 0);
      check_eq("t1_b4", 32'(bus.tx_data), 32'hDE);
      recv_bytes(r, 4, 7, -1, 0);
      check_eq("t1_end_valid", 32'(bus.tx_valid), 32'd0);

      // Filtered writes: r0 and trace disabled.
      drive_rec('{rd: 5'd0, data: 32'h11111111, pc: 12'h020});
      step();
      drive_rec('{rd: 5'd5, data: 32'h22222222, pc: 12'h024});
      trace_en = 1'b0;
      step();
      bus.wb_we = 1'b0;
      trace_en  = 1'b1;
      check_eq("t2_level", 32'(fifo_level), 32'd0);
      step();
      check_eq("t2_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("t2_level2", 32'(fifo_level), 32'd0);

      // Backpressure for 5 cycles on byte 4.
      r = '{rd: 5'd7, data: 32'hDEADBEEF, pc: 12'h345};
      write(r);
      wait_valid("t3_start");
      recv_bytes(r, 0, 7, 4, 5);
      check_eq("t3_end_valid", 32'(bus.tx_valid), 32'd0);

      // Overflow: record 0 moves into the output stage, 16 fill the FIFO, 4 drop.
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 21; i++) write(mk(i));
      check_eq("t4_level", 32'(fifo_level), 32'd16);
      check_eq("t4_drop", 32'(drop_cnt), 32'd4);
      check_eq("t4_ovf", 32'(overflow), 32'd1);
      check_eq("t4_hold_data", 32'(bus.tx_data), 32'hA5);
      bus.tx_ready = 1'b1;
      recv_bytes(mk(0), 0, 6, -1, 0);
      // Byte 7 handshakes with a full FIFO and a concurrent push.
      r_extra = mk(21);
      check_eq("t5_b7_data", 32'(bus.tx_data), 32'(pkt_byte(mk(0), 7)));
      drive_rec(r_extra);
      step();
      bus.wb_we = 1'b0;
      check_eq("t5_level", 32'(fifo_level), 32'd16);
      check_eq("t5_drop", 32'(drop_cnt), 32'd4);
      for (int k = 1; k <= 16; k++) recv_bytes(mk(k), 0, 7, -1, 0);
      recv_bytes(r_extra, 0, 7, -1, 0);
      check_eq("t4_drain_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("t4_drain_level", 32'(fifo_level), 32'd0);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      check_eq("t4_clr_drop", 32'(drop_cnt), 32'd0);
      check_eq("t4_clr_ovf", 32'(overflow), 32'd0);

      // Clear wins over a simultaneous drop, then reset mid-packet.
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 19; i++) write(mk(40 + i));
      check_eq("t6_drop2", 32'(drop_cnt), 32'd2);
      clr_stats = 1'b1;
      write(mk(60));
      clr_stats = 1'b0;
      check_eq("t6_clrwin_drop", 32'(drop_cnt), 32'd0);
      check_eq("t6_clrwin_ovf", 32'(overflow), 32'd0);
      write(mk(61));
      check_eq("t6_drop1", 32'(drop_cnt), 32'd1);
      check_eq("t6_ovf1", 32'(overflow), 32'd1);
      bus.tx_ready = 1'b1;
      recv_bytes(mk(40), 0, 2, -1, 0);
      check_eq("t6_b3_pre", 32'(bus.tx_data), 32'(pkt_byte(mk(40), 3)));
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_eq("t6_rst_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("t6_rst_data", 32'(bus.tx_data), 32'd0);
      check_eq("t6_rst_level", 32'(fifo_level), 32'd0);
      check_eq("t6_rst_drop", 32'(drop_cnt), 32'd0);
      check_eq("t6_rst_ovf", 32'(overflow), 32'd0);
      step();
      check_eq("t6_no_resume", 32'(bus.tx_valid), 32'd0);
      r = '{rd: 5'd31, data: 32'h01234567, pc: 12'hFED};
      write(r);
      step();
      recv_bytes(r, 0, 7, -1, 0);
      check_eq("t6_end_valid", 32'(bus.tx_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
